// File: rtl/tlp_dw_serializer.sv
// rtl/tlp_dw_serializer.sv - serializes one flat 3DW-header TLP into a 32-bit DW stream with sop/eop framing
module tlp_dw_serializer #(
   parameter int MAX_DATA_DW = 16,
   parameter int HDR_DW      = 3
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [32*(HDR_DW+MAX_DATA_DW)-1:0]  tlp_i,
   input  logic                                tlp_valid_i,
   output logic                                tlp_ready_o,
   output logic [31:0]                         dw_o,
   output logic                                dw_valid_o,
   input  logic                                dw_ready_i,
   output logic                                sop_o,
   output logic                                eop_o,
   output logic                                len_err_o,
   output logic                                busy_o
);

   localparam int         TLP_W   = 32*(HDR_DW+MAX_DATA_DW);
   localparam logic [9:0] MAX_LEN = 10'(MAX_DATA_DW);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state_q, state_d;
   logic [TLP_W-1:0]   buf_q, buf_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [4:0]         last_q, last_d;
   logic [31:0]        dw_q, dw_d;
   logic               valid_q, valid_d;
   logic               sop_q, sop_d;
   logic               eop_q, eop_d;
   logic               len_err_q, len_err_d;

   logic               with_data;
   logic [9:0]         len;
   logic [4:0]         data_dw;
   logic               clamp;
   logic               cap;
   logic               acc;

   // Header decode of the word on the input bus; only used at the capture cycle.
   always_comb begin
      with_data = tlp_i[TLP_W-2];
      len       = tlp_i[TLP_W-23 -: 10];
      data_dw   = 5'd0;
      clamp     = 1'b0;
      if (with_data) begin
         if (len == 10'd0 || len > MAX_LEN) begin
            data_dw = 5'(MAX_DATA_DW);
            clamp   = 1'b1;
         end else begin
            data_dw = len[4:0];
         end
      end
   end

   assign tlp_ready_o = (state_q == IDLE) || (eop_q && dw_ready_i);
   assign cap         = tlp_valid_i && tlp_ready_o;
   assign acc         = valid_q && dw_ready_i;

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      dw_d      = dw_q;
      valid_d   = valid_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      len_err_d = 1'b0;
      if (cap) begin
         // A capture on the eop beat reloads in place so the next TLP follows with no bubble.
         state_d   = SEND;
         buf_d     = tlp_i;
         cnt_d     = 5'd0;
         last_d    = 5'(HDR_DW-1) + data_dw;
         dw_d      = tlp_i[TLP_W-1 -: 32];
         valid_d   = 1'b1;
         sop_d     = 1'b1;
         eop_d     = 1'b0;
         len_err_d = clamp;
      end else if (acc) begin
         if (eop_q) begin
            state_d = IDLE;
            dw_d    = 32'd0;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
         end else begin
            buf_d   = {buf_q[TLP_W-33:0], 32'd0};
            cnt_d   = cnt_q + 5'd1;
            dw_d    = buf_q[TLP_W-33 -: 32];
            sop_d   = 1'b0;
            eop_d   = (cnt_q + 5'd1) == last_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         cnt_q     <= 5'd0;
         last_q    <= 5'd0;
         dw_q      <= 32'd0;
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         dw_q      <= dw_d;
         valid_q   <= valid_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         len_err_q <= len_err_d;
      end
   end

   assign dw_o       = dw_q;
   assign dw_valid_o = valid_q;
   assign sop_o      = sop_q;
   assign eop_o      = eop_q;
   assign len_err_o  = len_err_q;
   assign busy_o     = (state_q == SEND);

endmodule

// File: tb/tb_tlp_dw_serializer.sv
// tb/tb_tlp_dw_serializer.sv - scoreboard bench for tlp_dw_serializer
module tb_tlp_dw_serializer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [607:0] tlp_i = '0;
   logic         tlp_valid_i = 1'b0;
   logic         tlp_ready_o;
   logic [31:0]  dw_o;
   logic         dw_valid_o;
   logic         dw_ready_i = 1'b1;
   logic         sop_o;
   logic         eop_o;
   logic         len_err_o;
   logic         busy_o;

   int           n_checks = 0;
   int           n_err = 0;
   logic [33:0]  sb_q[$];
   int           beat_cyc[$];
   int           cyc = 0;
   int           beats_total = 0;
   logic         err_exp = 1'b0;
   bit           stall_mode = 0;
   bit           prev_stall = 0;
   logic [34:0]  prev_v = '0;

   tlp_dw_serializer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tlp_i       (tlp_i),
      .tlp_valid_i (tlp_valid_i),
      .tlp_ready_o (tlp_ready_o),
      .dw_o        (dw_o),
      .dw_valid_o  (dw_valid_o),
      .dw_ready_i  (dw_ready_i),
      .sop_o       (sop_o),
      .eop_o       (eop_o),
      .len_err_o   (len_err_o),
      .busy_o      (busy_o)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [607:0] make_tlp(input logic [2:0] fmt, input logic [4:0] typ,
                                             input logic [9:0] len);
      logic [607:0] t;
      for (int i = 0; i < 19; i++) t[32*i +: 32] = $urandom;
      t[607:605] = fmt;
      t[604:600] = typ;
      t[585:576] = len;
      return t;
   endfunction

   // Offer one TLP; on handshake push the expected beats derived from fmt/len.
   task automatic offer(input logic [607:0] t);
      bit got = 0;
      int waited = 0;
      int d;
      int total;
      logic [9:0] len;
      logic clamp;
      @(negedge clk);
      tlp_i = t;
      tlp_valid_i = 1'b1;
      while (!got && waited < 300) begin
         #2;
         if (tlp_ready_o) got = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      if (!got) begin
         chk("offer_timeout", 64'd0, 64'd1);
         tlp_valid_i = 1'b0;
         return;
      end
      @(posedge clk);
      len = t[585:576];
      clamp = t[606] && (len == 10'd0 || len > 10'd16);
      d = !t[606] ? 0 : (clamp ? 16 : int'(len));
      total = 3 + d;
      err_exp = clamp;
      for (int i = 0; i < total; i++)
         sb_q.push_back({(i == 0), (i == total-1), t[607-32*i -: 32]});
   endtask

   task automatic release_valid();
      @(negedge clk);
      tlp_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb_q.size() != 0 || busy_o) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial forever begin
      @(negedge clk);
      dw_ready_i = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   initial forever begin
      logic [33:0] e;
      @(negedge clk);
      #3;
      cyc++;
      if (dw_valid_o && dw_ready_i) begin
         if (sb_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
         else begin
            e = sb_q.pop_front();
            chk("beat", 64'({sop_o, eop_o, dw_o}), 64'(e));
         end
         beats_total++;
         beat_cyc.push_back(cyc);
      end
      if (!dw_valid_o) chk("idle_zero", 64'({sop_o, eop_o, dw_o}), 64'd0);
      chk("ready_rule", 64'(tlp_ready_o), 64'(!busy_o || (eop_o && dw_ready_i)));
      chk("len_err", 64'(len_err_o), 64'(err_exp));
      err_exp = 1'b0;
      if (prev_stall) chk("stall_hold", 64'({dw_valid_o, sop_o, eop_o, dw_o}), 64'(prev_v));
      prev_stall = dw_valid_o && !dw_ready_i;
      prev_v = {dw_valid_o, sop_o, eop_o, dw_o};
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      int b0;
      int n;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(dw_valid_o), 64'd0);
      chk("rst_ready", 64'(tlp_ready_o), 64'd1);
      chk("rst_outs", 64'({sop_o, eop_o, len_err_o, busy_o, dw_o}), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      offer(make_tlp(3'b010, 5'b00000, 10'd4));   release_valid(); wait_drain();
      offer(make_tlp(3'b000, 5'b00000, 10'd8));   release_valid(); wait_drain();
      offer(make_tlp(3'b010, 5'b01010, 10'd0));   release_valid(); wait_drain();
      offer(make_tlp(3'b010, 5'b01010, 10'd20));  release_valid(); wait_drain();
      offer(make_tlp(3'b011, 5'b00000, 10'd16));  release_valid(); wait_drain();
      offer(make_tlp(3'b001, 5'b00100, 10'd0));   release_valid(); wait_drain();

      beat_cyc.delete();
      offer(make_tlp(3'b010, 5'b00000, 10'd1));
      offer(make_tlp(3'b010, 5'b00000, 10'd1));
      release_valid();
      wait_drain();
      chk("b2b_beats", 64'(beat_cyc.size()), 64'd8);
      if (beat_cyc.size() == 8) chk("b2b_span", 64'(beat_cyc[7] - beat_cyc[0]), 64'd7);

      stall_mode = 1;
      offer(make_tlp(3'b010, 5'b00000, 10'd16));  release_valid(); wait_drain();
      for (int k = 0; k < 4; k++) begin
         offer(make_tlp(3'b010, 5'b00000, 10'($urandom_range(0, 18))));
      end
      release_valid();
      wait_drain();
      stall_mode = 0;
      repeat (2) @(negedge clk);

      offer(make_tlp(3'b010, 5'b00000, 10'd16));
      release_valid();
      b0 = beats_total;
      n = 0;
      while (beats_total < b0 + 2 && n < 100) begin
         @(negedge clk);
         #4;
         n++;
      end
      if (n >= 100) chk("rst_wait_timeout", 64'd0, 64'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outs", 64'({dw_valid_o, sop_o, eop_o, len_err_o, busy_o, dw_o}), 64'd0);
      chk("midrst_ready", 64'(tlp_ready_o), 64'd1);
      sb_q.delete();
      err_exp = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      b0 = beats_total;
      offer(make_tlp(3'b010, 5'b00000, 10'd2));
      release_valid();
      wait_drain();
      chk("post_rst_beats", 64'(beats_total - b0), 64'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
